// File: rtl/spi_cmd_decoder.sv
`default_nettype none
// ============================================================================
// Module   : spi_cmd_decoder
// Purpose  : Turns the SPI slave's receive byte stream into single-beat
//            register bus writes and reads, and sends back a write-ack byte
//            or the read data bytes on the transmit byte stream.
//
//            Packet: opcode, start address A, length N, then N data bytes
//            for writes. Reads fetch N bytes starting at A. Addresses wrap
//            modulo 256. An idle gap inside a packet longer than
//            TIMEOUT_CYCLES aborts the packet. Bad opcodes, bad lengths and
//            timeouts bump a saturating error counter.
//
// Ports    : i_clk          system clock
//            i_reset        asynchronous reset, active low
//            i_axis_tdata   received byte
//            i_axis_tvalid  received byte strobe
//            o_axis_tready  decoder can accept a byte
//            o_axis_tdata   response byte
//            o_axis_tvalid  response byte valid
//            i_axis_tready  downstream accepts the response byte
//            o_reg_addr     register address (A + k)
//            o_reg_wdata    register write data
//            o_reg_we       write strobe, one cycle per data byte
//            o_reg_re       read strobe, one cycle per read byte
//            i_reg_rdata    read data, valid one cycle after o_reg_re
//            o_busy         packet in progress
//            o_err_count    saturating protocol error count
//
// Revision : 1.0 - initial release
// ============================================================================
module spi_cmd_decoder #(
    parameter logic [7:0] CMD_WR         = 8'hA5,
    parameter logic [7:0] CMD_RD         = 8'h5A,
    parameter logic [7:0] ACK_BYTE       = 8'hAC,
    parameter int         MAX_LEN        = 16,
    parameter int         TIMEOUT_CYCLES = 100000
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [7:0] i_axis_tdata,
    input  logic       i_axis_tvalid,
    output logic       o_axis_tready,
    output logic [7:0] o_axis_tdata,
    output logic       o_axis_tvalid,
    input  logic       i_axis_tready,
    output logic [7:0] o_reg_addr,
    output logic [7:0] o_reg_wdata,
    output logic       o_reg_we,
    output logic       o_reg_re,
    input  logic [7:0] i_reg_rdata,
    output logic       o_busy,
    output logic [7:0] o_err_count
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int               c_TO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]       c_MAX_LEN = 8'(MAX_LEN);

    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_ADDR    = 3'd1;
    localparam logic [2:0] c_LEN     = 3'd2;
    localparam logic [2:0] c_WDATA   = 3'd3;
    localparam logic [2:0] c_ACK     = 3'd4;
    localparam logic [2:0] c_RD_REQ  = 3'd5;
    localparam logic [2:0] c_RD_WAIT = 3'd6;
    localparam logic [2:0] c_RD_SEND = 3'd7;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [2:0]        r_state;
    logic              r_is_wr;     // opcode of the packet in flight
    logic [7:0]        r_addr;      // start address A
    logic [7:0]        r_len;       // payload length N
    logic [7:0]        r_cnt;       // byte index k
    logic [c_TO_W-1:0] r_to_cnt;    // idle cycles since the last accepted byte
    logic [7:0]        r_tx_data;
    logic              r_tx_valid;
    logic [7:0]        r_err_count;

    // ------------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------------
    logic       w_tready;
    logic       w_accept;
    logic       w_out_hs;
    logic       w_timed;
    logic       w_timeout;
    logic       w_op_ok;
    logic       w_len_bad;
    logic       w_err_inc;
    logic [7:0] w_cnt_next;

    assign w_tready   = (r_state == c_IDLE) || (r_state == c_ADDR) ||
                        (r_state == c_LEN)  || (r_state == c_WDATA);
    assign w_accept   = i_axis_tvalid && w_tready;
    assign w_out_hs   = r_tx_valid && i_axis_tready;
    assign w_cnt_next = r_cnt + 8'd1;

    // The inter-byte watchdog only guards the inbound part of a packet.
    assign w_timed    = (r_state == c_ADDR) || (r_state == c_LEN) ||
                        (r_state == c_WDATA);

    // A byte arriving in the expiry cycle wins: it resets the watchdog.
    assign w_timeout  = w_timed && !w_accept && (r_to_cnt == c_TO_LAST);

    assign w_op_ok    = (i_axis_tdata == CMD_WR) || (i_axis_tdata == CMD_RD);
    assign w_len_bad  = (i_axis_tdata == 8'd0) || (i_axis_tdata > c_MAX_LEN);

    // Error sources belong to different states, so at most one fires per cycle.
    assign w_err_inc  = ((r_state == c_IDLE) && w_accept && !w_op_ok) ||
                        ((r_state == c_LEN)  && w_accept && w_len_bad) ||
                        w_timeout;

    // ------------------------------------------------------------------------
    // Packet state machine
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state    <= c_IDLE;
            r_is_wr    <= 1'b0;
            r_addr     <= 8'h00;
            r_len      <= 8'h00;
            r_cnt      <= 8'h00;
            r_tx_data  <= 8'h00;
            r_tx_valid <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_accept && w_op_ok) begin
                        r_is_wr <= (i_axis_tdata == CMD_WR);
                        r_state <= c_ADDR;
                    end
                end

                c_ADDR: begin
                    if (w_accept) begin
                        r_addr  <= i_axis_tdata;
                        r_state <= c_LEN;
                    end else if (w_timeout) begin
                        r_state <= c_IDLE;
                    end
                end

                c_LEN: begin
                    if (w_accept) begin
                        if (w_len_bad) begin
                            r_state <= c_IDLE;
                        end else begin
                            r_len   <= i_axis_tdata;
                            r_cnt   <= 8'h00;
                            r_state <= r_is_wr ? c_WDATA : c_RD_REQ;
                        end
                    end else if (w_timeout) begin
                        r_state <= c_IDLE;
                    end
                end

                c_WDATA: begin
                    // The register write itself is issued combinationally in
                    // the accept cycle; here we only advance k.
                    if (w_accept) begin
                        r_cnt <= w_cnt_next;
                        if (w_cnt_next == r_len) begin
                            r_tx_data  <= ACK_BYTE;
                            r_tx_valid <= 1'b1;
                            r_state    <= c_ACK;
                        end
                    end else if (w_timeout) begin
                        r_state <= c_IDLE;
                    end
                end

                c_ACK: begin
                    if (w_out_hs) begin
                        r_tx_valid <= 1'b0;
                        r_state    <= c_IDLE;
                    end
                end

                c_RD_REQ: begin
                    r_state <= c_RD_WAIT;
                end

                c_RD_WAIT: begin
                    // Read data is valid in this cycle only.
                    r_tx_data  <= i_reg_rdata;
                    r_tx_valid <= 1'b1;
                    r_state    <= c_RD_SEND;
                end

                c_RD_SEND: begin
                    // r_tx_data is untouched until the handshake, which keeps
                    // the beat stable under backpressure.
                    if (w_out_hs) begin
                        r_tx_valid <= 1'b0;
                        r_cnt      <= w_cnt_next;
                        r_state    <= (w_cnt_next == r_len) ? c_IDLE : c_RD_REQ;
                    end
                end

                default: begin
                    r_tx_valid <= 1'b0;
                    r_state    <= c_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Inter-byte watchdog
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_to_cnt <= '0;
        end else if (!w_timed || w_accept || w_timeout) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Saturating error counter
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_err_count <= 8'h00;
        end else if (w_err_inc && (r_err_count != 8'hFF)) begin
            r_err_count <= r_err_count + 8'd1;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    // Register bus strobes are decoded from state so the write lands in the
    // same cycle as its data byte and the read strobe lasts exactly one cycle.
    assign o_reg_we      = (r_state == c_WDATA) && i_axis_tvalid;
    assign o_reg_re      = (r_state == c_RD_REQ);
    assign o_reg_addr    = r_addr + r_cnt;     // wraps modulo 256
    assign o_reg_wdata   = o_reg_we ? i_axis_tdata : 8'h00;

    assign o_axis_tready = w_tready;
    assign o_axis_tdata  = r_tx_data;
    assign o_axis_tvalid = r_tx_valid;
    assign o_busy        = (r_state != c_IDLE);
    assign o_err_count   = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_spi_cmd_decoder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_spi_cmd_decoder
// Purpose  : Directed self-checking bench for spi_cmd_decoder: write packet,
//            read with backpressure, protocol errors, address wrap with
//            inter-byte timeout, and asynchronous reset mid-response.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_cmd_decoder;

    localparam int c_TO = 40;

    logic       clk;
    logic       i_reset;
    logic [7:0] i_axis_tdata;
    logic       i_axis_tvalid;
    logic       o_axis_tready;
    logic [7:0] o_axis_tdata;
    logic       o_axis_tvalid;
    logic       i_axis_tready;
    logic [7:0] o_reg_addr;
    logic [7:0] o_reg_wdata;
    logic       o_reg_we;
    logic       o_reg_re;
    logic [7:0] i_reg_rdata;
    logic       o_busy;
    logic [7:0] o_err_count;

    int errors = 0;
    int checks = 0;

    // Register file model and observed traffic
    logic [7:0] mem [256];
    logic [7:0] beats [$];
    int         we_count = 0;

    // Register bus signals sampled while a byte is being presented
    logic       s_we;
    logic [7:0] s_addr;
    logic [7:0] s_wdata;

    int         we_base;
    int         beat_base;
    int         n;

    spi_cmd_decoder #(
        .CMD_WR         (8'hA5),
        .CMD_RD         (8'h5A),
        .ACK_BYTE       (8'hAC),
        .MAX_LEN        (16),
        .TIMEOUT_CYCLES (c_TO)
    ) u_dut (
        .i_clk         (clk),
        .i_reset       (i_reset),
        .i_axis_tdata  (i_axis_tdata),
        .i_axis_tvalid (i_axis_tvalid),
        .o_axis_tready (o_axis_tready),
        .o_axis_tdata  (o_axis_tdata),
        .o_axis_tvalid (o_axis_tvalid),
        .i_axis_tready (i_axis_tready),
        .o_reg_addr    (o_reg_addr),
        .o_reg_wdata   (o_reg_wdata),
        .o_reg_we      (o_reg_we),
        .o_reg_re      (o_reg_re),
        .i_reg_rdata   (i_reg_rdata),
        .o_busy        (o_busy),
        .o_err_count   (o_err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register slave with one-cycle read latency, plus traffic monitors
    always @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            i_reg_rdata <= 8'h00;
        end else begin
            if (o_reg_re) i_reg_rdata <= mem[o_reg_addr];
            if (o_reg_we) we_count = we_count + 1;
            if (o_axis_tvalid && i_axis_tready) beats.push_back(o_axis_tdata);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one byte for one cycle; register bus outputs are sampled mid-cycle.
    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        i_axis_tdata  = b;
        i_axis_tvalid = 1'b1;
        @(negedge clk);
        s_we    = o_reg_we;
        s_addr  = o_reg_addr;
        s_wdata = o_reg_wdata;
        @(posedge clk); #1;
        i_axis_tvalid = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int max_cycles);
        int k;
        k = 0;
        while (o_busy !== 1'b0 && k < max_cycles) begin
            @(negedge clk);
            k++;
        end
        check(tag, 32'(o_busy), 32'd0);
    endtask

    function automatic logic [31:0] beat_at(input int idx);
        if (idx < beats.size()) return 32'(beats[idx]);
        return 32'hFFFF_FFFF;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h20] = 8'h5E;
        mem[8'h21] = 8'h6F;
        i_reset       = 1'b0;
        i_axis_tdata  = 8'h00;
        i_axis_tvalid = 1'b0;
        i_axis_tready = 1'b1;

        // ---------------- reset state ----------------
        repeat (3) @(negedge clk);
        check("rst_tready", 32'(o_axis_tready), 32'd1);
        check("rst_tvalid", 32'(o_axis_tvalid), 32'd0);
        check("rst_tdata",  32'(o_axis_tdata),  32'h00);
        check("rst_we",     32'(o_reg_we),      32'd0);
        check("rst_re",     32'(o_reg_re),      32'd0);
        check("rst_addr",   32'(o_reg_addr),    32'h00);
        check("rst_wdata",  32'(o_reg_wdata),   32'h00);
        check("rst_busy",   32'(o_busy),        32'd0);
        check("rst_err",    32'(o_err_count),   32'h00);
        i_reset = 1'b1;

        // ---------------- write packet ----------------
        we_base   = we_count;
        beat_base = beats.size();
        send_byte(8'hA5);
        send_byte(8'h10);
        send_byte(8'h02);
        send_byte(8'h11);
        check("wr0_we",    32'(s_we),    32'd1);
        check("wr0_addr",  32'(s_addr),  32'h10);
        check("wr0_wdata", 32'(s_wdata), 32'h11);
        send_byte(8'h22);
        check("wr1_we",    32'(s_we),    32'd1);
        check("wr1_addr",  32'(s_addr),  32'h11);
        check("wr1_wdata", 32'(s_wdata), 32'h22);
        wait_idle("wr_idle", 20);
        check("wr_we_count",   32'(we_count - we_base),       32'd2);
        check("wr_beat_count", 32'(beats.size() - beat_base), 32'd1);
        check("wr_ack_byte",   beat_at(beat_base),            32'hAC);

        // ---------------- read with backpressure ----------------
        i_axis_tready = 1'b0;
        beat_base = beats.size();
        send_byte(8'h5A);
        send_byte(8'h20);
        send_byte(8'h02);
        @(negedge clk);
        check("rd_re",       32'(o_reg_re),   32'd1);
        check("rd_re_addr",  32'(o_reg_addr), 32'h20);
        @(negedge clk);
        check("rd_wait_tvalid", 32'(o_axis_tvalid), 32'd0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("rd_hold_tvalid_%0d", c), 32'(o_axis_tvalid), 32'd1);
            check($sformatf("rd_hold_tdata_%0d", c),  32'(o_axis_tdata),  32'h5E);
        end
        i_axis_tready = 1'b1;
        wait_idle("rd_idle", 30);
        check("rd_beat_count", 32'(beats.size() - beat_base), 32'd2);
        check("rd_beat0",      beat_at(beat_base),            32'h5E);
        check("rd_beat1",      beat_at(beat_base + 1),        32'h6F);

        // ---------------- protocol errors ----------------
        we_base   = we_count;
        beat_base = beats.size();
        send_byte(8'h33);
        check("err_opcode_count", 32'(o_err_count), 32'd1);
        check("err_opcode_busy",  32'(o_busy),      32'd0);
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h00);
        check("err_len0_count", 32'(o_err_count), 32'd2);
        check("err_len0_busy",  32'(o_busy),      32'd0);
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h11);
        check("err_len17_count", 32'(o_err_count), 32'd3);
        check("err_len17_busy",  32'(o_busy),      32'd0);
        repeat (4) @(negedge clk);
        check("err_no_writes", 32'(we_count - we_base),       32'd0);
        check("err_no_beats",  32'(beats.size() - beat_base), 32'd0);

        // ---------------- address wrap and timeout ----------------
        we_base   = we_count;
        beat_base = beats.size();
        send_byte(8'hA5);
        send_byte(8'hFF);
        send_byte(8'h02);
        send_byte(8'hAA);
        check("wrap_we",    32'(s_we),    32'd1);
        check("wrap_addr",  32'(s_addr),  32'hFF);
        check("wrap_wdata", 32'(s_wdata), 32'hAA);
        repeat (c_TO / 2) @(negedge clk);
        check("to_early_busy", 32'(o_busy),      32'd1);
        check("to_early_err",  32'(o_err_count), 32'd3);
        repeat (c_TO / 2 + 5) @(negedge clk);
        check("to_busy",      32'(o_busy),                   32'd0);
        check("to_err",       32'(o_err_count),              32'd4);
        check("to_writes",    32'(we_count - we_base),       32'd1);
        check("to_no_ack",    32'(beats.size() - beat_base), 32'd0);
        send_byte(8'hA5);
        send_byte(8'hFF);
        send_byte(8'h02);
        check("re_wr_busy",   32'(o_busy),        32'd1);
        check("re_wr_tready", 32'(o_axis_tready), 32'd1);
        check("re_wr_err",    32'(o_err_count),   32'd4);
        send_byte(8'h01);
        check("re_wr0_addr", 32'(s_addr), 32'hFF);
        send_byte(8'h02);
        check("re_wr1_addr",  32'(s_addr),  32'h00);
        check("re_wr1_wdata", 32'(s_wdata), 32'h02);
        wait_idle("re_wr_idle", 20);
        check("re_wr_ack", beat_at(beat_base), 32'hAC);

        // ---------------- async reset during a pending read beat ----------------
        i_axis_tready = 1'b0;
        send_byte(8'h5A);
        send_byte(8'h20);
        send_byte(8'h02);
        n = 0;
        while (o_axis_tvalid !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("ar_pre_tvalid", 32'(o_axis_tvalid), 32'd1);
        @(negedge clk); #2;
        i_reset = 1'b0;
        #1;
        check("ar_tvalid", 32'(o_axis_tvalid), 32'd0);
        check("ar_busy",   32'(o_busy),        32'd0);
        check("ar_tready", 32'(o_axis_tready), 32'd1);
        check("ar_err",    32'(o_err_count),   32'd0);
        @(negedge clk);
        i_reset       = 1'b1;
        i_axis_tready = 1'b1;
        beat_base = beats.size();
        send_byte(8'h5A);
        send_byte(8'h21);
        send_byte(8'h01);
        wait_idle("ar_rd_idle", 20);
        check("ar_rd_count", 32'(beats.size() - beat_base), 32'd1);
        check("ar_rd_beat",  beat_at(beat_base),            32'h6F);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spi_cmd_decoder.md
Name: spi_cmd_decoder

Overview:
- Sits directly downstream of the SPI slave's receive byte stream.
- Parses framed command packets into single-beat register writes and reads on a simple register bus.
- Returns a write-acknowledge byte, or the read data bytes, on an output byte stream that feeds the SPI transmit FIFO.
- Counts protocol errors and aborts stalled packets with an inter-byte timeout.

Parameters:
- CMD_WR, 8'hA5, opcode for a write packet.
- CMD_RD, 8'h5A, opcode for a read packet.
- ACK_BYTE, 8'hAC, response byte emitted after a completed write packet.
- MAX_LEN, 16, maximum payload length; legal range 1..255.
- TIMEOUT_CYCLES, 100000, maximum i_clk cycles allowed between bytes inside a packet.

Ports:
- i_clk  in  1  system clock
- i_reset  in  1  asynchronous, active-low reset
- i_axis_tdata  in  8  received SPI byte
- i_axis_tvalid  in  1  received byte valid, single-cycle strobe
- o_axis_tready  out  1  decoder can accept an input byte
- o_axis_tdata  out  8  response byte
- o_axis_tvalid  out  1  response byte valid
- i_axis_tready  in  1  downstream accepts the response byte
- o_reg_addr  out  8  register address
- o_reg_wdata  out  8  register write data
- o_reg_we  out  1  write strobe, one cycle
- o_reg_re  out  1  read strobe, one cycle
- i_reg_rdata  in  8  read data, valid exactly 1 cycle after o_reg_re
- o_busy  out  1  high in any state other than IDLE
- o_err_count  out  8  saturating protocol error count

Behaviour:
- Reset (i_reset=0, asynchronous):
  - State goes to IDLE.
  - All outputs go to 0, except o_axis_tready=1.
  - Timeout counter, address, length and byte count registers clear.
- Input handshake: a byte is consumed when i_axis_tvalid && o_axis_tready.
  - o_axis_tready=1 only in IDLE, ADDR, LEN and WDATA.
  - Bytes presented while o_axis_tready=0 are dropped. They are not counted as errors.
- Output handshake (AXI-stream rules):
  - o_axis_tdata is held stable while o_axis_tvalid=1 && i_axis_tready=0.
  - The beat completes on the cycle where both are high.
- Packet format:
  - Byte 0: opcode. Byte 1: start address A. Byte 2: length N.
  - Write packets then carry N data bytes.
- States and transitions:
  - IDLE: opcode == CMD_WR or CMD_RD -> ADDR. Any other opcode: err+1, stay in IDLE.
  - ADDR: latch A -> LEN.
  - LEN: N == 0 or N > MAX_LEN: err+1 -> IDLE. Otherwise latch N, clear byte count k, go to WDATA (write) or RD_REQ (read).
  - WDATA: on each byte, in that same cycle assert o_reg_we=1, o_reg_addr=A+k, o_reg_wdata=byte; then k+1. After byte N -> ACK.
  - ACK: o_axis_tvalid=1, o_axis_tdata=ACK_BYTE. On handshake -> IDLE.
  - RD_REQ: o_reg_re=1 for one cycle, o_reg_addr=A+k -> RD_WAIT.
  - RD_WAIT: capture i_reg_rdata into the output register, set o_axis_tvalid=1 -> RD_SEND.
  - RD_SEND: on handshake, k+1. If k == N -> IDLE, else -> RD_REQ.
- Read latency: 2 cycles from o_reg_re to o_axis_tvalid.
- Address arithmetic: A+k is modulo 256, so address 8'hFF wraps to 8'h00.
- Timeout:
  - The counter runs only in ADDR, LEN and WDATA, and clears on each accepted byte.
  - On reaching TIMEOUT_CYCLES: err+1, go to IDLE, discard the partial packet.
  - Register writes already issued are not undone.
- o_err_count saturates at 8'hFF.
- Simultaneous events: in the cycle where the timeout expires and a byte also arrives, the byte wins and the counter clears.
- Reset mid-packet: any pending response beat is abandoned immediately; o_axis_tvalid falls asynchronously.

Test Plan:
- Write: bytes A5,10,02,11,22 -> o_reg_we pulses at addr 10 data 11, then addr 11 data 22; then one response beat AC; o_busy returns to 0.
- Read with backpressure: regs 0x20=5E, 0x21=6F; bytes 5A,20,02; i_axis_tready held low 5 cycles -> o_axis_tdata stays 5E throughout; then 5E and 6F are delivered in order.
- Errors: bytes 33, then A5,00,00, then A5,00,11 -> err count 3; no o_reg_we pulses; no response beats.
- Wrap and timeout: bytes A5,FF,02,AA -> write AA at FF. Then stall TIMEOUT_CYCLES -> err+1, state IDLE, no write at 00, no ACK. A new A5,FF,02 is then accepted normally.
- Async reset during RD_SEND with o_axis_tvalid=1 -> o_axis_tvalid drops without waiting for i_clk. After release, a new read packet completes correctly.
